lsu_writeback: RTL

//  Load/store unit and write-back stage for the RV32I core. Takes one memory op from execute,

---
 rtl/rv32i_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu_writeback.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding,
// exception cause codes and the legality/alignment helpers used at issue.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2,
    ST_EXC  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_cause_e;

  // Stores only have byte/half/word; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store enables/replicated data, and load
// extraction with sign or zero extension.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offs,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offs, 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = shifted;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << offs;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be        = offs[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_writeback.sv
// Load/store unit plus write-back: issue checks, data-memory handshake with
// bus timeout, and the register-file write port.
module lsu_writeback
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        exc,
  output logic [1:0]  exc_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd
);

  lsu_state_e  state_q, state_d;
  exc_cause_e  cause_q, cause_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, sd_q, ld_q;
  logic [2:0]  f3_q;
  logic        st_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_in;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_data;

  assign addr_in = base + offset;

  lsu_align u_align (
    .funct3     (f3_q),
    .offs       (addr_q[1:0]),
    .store_data (sd_q),
    .rdata      (mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!f3_legal(is_store, funct3)) begin
            state_d = ST_EXC;
            cause_d = EXC_ILLEGAL;
          end else if (misaligned(funct3, addr_in[1:0])) begin
            state_d = ST_EXC;
            cause_d = EXC_MISALIGN;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = ST_EXC;
          cause_d = EXC_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= EXC_NONE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      sd_q    <= 32'd0;
      ld_q    <= 32'd0;
      f3_q    <= 3'd0;
      st_q    <= 1'b0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == ST_IDLE && start) begin
        addr_q <= addr_in;
        sd_q   <= store_data;
        f3_q   <= funct3;
        st_q   <= is_store;
        rd_q   <= rd;
      end
      // Counts only stalled REQ cycles; any other state leaves it cleared.
      if (state_q == ST_REQ && !mem_ready) cnt_q <= cnt_q + 8'd1;
      else                                 cnt_q <= 8'd0;
      if (state_q == ST_REQ && mem_ready) ld_q <= load_data;
    end
  end

  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_WB;
  assign exc       = state_q == ST_EXC;
  assign exc_cause = exc ? cause_q : EXC_NONE;

  assign mem_req   = state_q == ST_REQ;
  assign mem_we    = mem_req & st_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? (st_q ? lane_be : 4'b1111) : 4'b0000;
  assign mem_wdata = (mem_req && st_q) ? lane_wdata : 32'd0;

  assign rf_we     = done & ~st_q & (rd_q != 5'd0);
  assign rf_a3     = rf_we ? rd_q : 5'd0;
  assign rf_wd     = rf_we ? ld_q : 32'd0;

endmodule
